// File: rtl/ads1256_scan.sv
// ADS1256 scanner: per channel WREG(MUX), SYNC, WAKEUP, RDATA, then a 24-bit read into a result bank.
// Latency ~2.7k clocks/channel at defaults; no backpressure, start ignored while busy, rd_data one clock after rd_addr.
module ads1256_scan #(
  parameter int NUM_CH         = 2,
  parameter int SCLK_HALF      = 16,
  parameter int T6_CYCLES      = 350,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CS_GAP         = 8
) (
  input  logic              CLK_50M,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              err_clr,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS,
  input  logic              DRDY,
  input  logic [2:0]        rd_addr,
  output logic [23:0]       rd_data,
  output logic [NUM_CH-1:0] valid,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT1, S_WREG, S_SYNC, S_WAKEUP, S_WAIT2,
    S_RDATA, S_T6, S_READ, S_STORE, S_GAP
  } state_t;

  state_t              state_q;
  logic [2:0]          ch_q;
  logic [23:0]         cnt_q;
  logic [15:0]         div_q;
  logic [4:0]          bits_q;
  logic [23:0]         shift_q;
  logic                sclk_q, mosi_q, cs_q;
  logic                busy_q, done_q, err_q;
  logic                drdy_meta_q, drdy_s_q;
  logic [NUM_CH-1:0]   valid_q;
  logic [23:0]         result_q [NUM_CH];
  logic [23:0]         rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_addr == 3'(k)) rd_data_d = result_q[k];
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      bits_q      <= '0;
      shift_q     <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drdy_meta_q <= 1'b1;
      drdy_s_q    <= 1'b1;
      valid_q     <= '0;
      rd_data_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) result_q[k] <= '0;
    end else begin
      drdy_meta_q <= DRDY;
      drdy_s_q    <= drdy_meta_q;
      done_q      <= 1'b0;
      rd_data_q   <= rd_data_d;
      // A timeout assignment later in this block overrides the clear.
      if (err_clr) err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start || cont) begin
            ch_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT1;
          end
        end

        S_WAIT1, S_WAIT2: begin
          if (!drdy_s_q) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            cs_q   <= 1'b0;
            if (state_q == S_WAIT1) begin
              shift_q <= {8'h51, 8'h00, 1'b0, ch_q, 4'h8};
              bits_q  <= 5'd24;
              state_q <= S_WREG;
            end else begin
              shift_q <= {8'h01, 16'h0000};
              bits_q  <= 5'd8;
              state_q <= S_RDATA;
            end
          end else if (cnt_q == 24'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            cs_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        S_WREG, S_SYNC, S_WAKEUP, S_RDATA, S_READ: begin
          if (div_q == 16'(SCLK_HALF - 1)) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              mosi_q <= (state_q == S_READ) ? 1'b0 : shift_q[23];
            end else begin
              // Falling edge: the slave's bit has been stable for half a period.
              sclk_q  <= 1'b0;
              shift_q <= {shift_q[22:0], MISO};
              bits_q  <= bits_q - 5'd1;
              if (bits_q == 5'd1) begin
                cnt_q  <= '0;
                bits_q <= 5'd8;
                case (state_q)
                  S_WREG: begin
                    shift_q <= {8'hFC, 16'h0000};
                    state_q <= S_SYNC;
                  end
                  S_SYNC: begin
                    shift_q <= '0;
                    state_q <= S_WAKEUP;
                  end
                  S_WAKEUP: state_q <= S_WAIT2;
                  S_RDATA:  state_q <= S_T6;
                  default:  state_q <= S_STORE;
                endcase
              end
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end

        S_T6: begin
          mosi_q <= 1'b0;
          if (cnt_q == 24'(T6_CYCLES - 1)) begin
            shift_q <= '0;
            bits_q  <= 5'd24;
            div_q   <= '0;
            state_q <= S_READ;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        S_STORE: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == 3'(k)) begin
              result_q[k] <= shift_q;
              valid_q[k]  <= 1'b1;
            end
          end
          cs_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_GAP;
        end

        S_GAP: begin
          cs_q <= 1'b1;
          if (cnt_q == 24'(CS_GAP - 1)) begin
            cnt_q <= '0;
            if (ch_q != 3'(NUM_CH - 1)) begin
              ch_q    <= ch_q + 3'd1;
              state_q <= S_WAIT1;
            end else begin
              done_q <= 1'b1;
              ch_q   <= '0;
              if (cont) begin
                state_q <= S_WAIT1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign CS          = cs_q;
  assign rd_data     = rd_data_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign scan_done   = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_ads1256_scan.sv
// Directed bench for ads1256_scan with a behavioural ADS1256 SPI slave.
// Checks command bytes, readback table, timeout, continuous scanning and reset abort.
module tb_ads1256_scan;

  localparam int NUM_CH = 2;

  logic clk = 1'b0;
  logic rst, start, cont, err_clr;
  logic SCLK, MOSI, MISO, CS, DRDY;
  logic [2:0] rd_addr;
  logic [23:0] rd_data;
  logic [NUM_CH-1:0] valid;
  logic busy, scan_done, timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ads1256_scan #(
    .NUM_CH(NUM_CH), .SCLK_HALF(16), .T6_CYCLES(350),
    .TIMEOUT_CYCLES(100), .CS_GAP(8)
  ) dut (
    .CLK_50M(clk), .rst(rst), .start(start), .cont(cont), .err_clr(err_clr),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS), .DRDY(DRDY),
    .rd_addr(rd_addr), .rd_data(rd_data), .valid(valid),
    .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
  );

  // ---------------- slave model and monitors ----------------
  logic [23:0] slave_data [8];
  logic [7:0]  mosi_q [$];
  logic [7:0]  bit_acc;
  logic [3:0]  cur_ch = 4'd0;
  bit          inc_mode = 1'b0;
  int          fb = 0;
  int          cyc = 0, done_cnt = 0, idle_cnt = 0;
  bit          busy_watch = 1'b0;
  int          t_r0, t_r1, t_rd_last, t_rd_first;

  always @(negedge clk) begin
    cyc++;
    if (scan_done) done_cnt++;
    if (busy_watch && !busy) idle_cnt++;
  end

  always @(negedge SCLK or posedge CS) begin
    if (CS) begin
      fb = 0;
      bit_acc = 8'h00;
    end else begin
      bit_acc = {bit_acc[6:0], MOSI};
      if (fb < 48 && (fb % 8) == 7) mosi_q.push_back(bit_acc);
      if (fb == 23) cur_ch = bit_acc[7:4];
      if (fb == 47) t_rd_last = cyc;
      if (fb == 71 && inc_mode) slave_data[cur_ch[2:0]] = slave_data[cur_ch[2:0]] + 24'd1;
      fb++;
    end
  end

  always @(posedge SCLK) begin
    logic [23:0] w;
    if (!CS) begin
      if (fb == 0) t_r0 = cyc;
      if (fb == 1) t_r1 = cyc;
      if (fb == 48) t_rd_first = cyc;
      if (fb >= 48 && fb < 72) begin
        w = slave_data[cur_ch[2:0]];
        MISO = w[71 - fb];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    chk(name, done_cnt, target);
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [23:0] exp);
    rd_addr = a;
    step();
    chk(name, rd_data, exp);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [23:0] exp;
  } rd_vec_t;

  rd_vec_t    rd_tab [8];
  logic [7:0] mosi_exp [12];

  initial begin
    int d0;

    rd_tab[0] = '{3'd0, 24'h123456};
    rd_tab[1] = '{3'd1, 24'hABCDEF};
    rd_tab[2] = '{3'd2, 24'h000000};
    rd_tab[3] = '{3'd3, 24'h000000};
    rd_tab[4] = '{3'd7, 24'h000000};
    rd_tab[5] = '{3'd0, 24'h123456};
    rd_tab[6] = '{3'd5, 24'h000000};
    rd_tab[7] = '{3'd1, 24'hABCDEF};
    mosi_exp = '{8'h51, 8'h00, 8'h08, 8'hFC, 8'h00, 8'h01,
                 8'h51, 8'h00, 8'h18, 8'hFC, 8'h00, 8'h01};
    for (int k = 0; k < 8; k++) slave_data[k] = 24'h0;
    slave_data[0] = 24'h123456;
    slave_data[1] = 24'hABCDEF;

    rst = 1'b1; start = 1'b0; cont = 1'b0; err_clr = 1'b0;
    DRDY = 1'b0; MISO = 1'b0; rd_addr = 3'd0;
    step(3);

    // Reset state
    chk("rst_cs", CS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step(2);

    // Single scan with start pulses injected while busy
    mosi_q.delete();
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    step(5);
    chk("scan1_busy", busy, 1);
    for (int i = 0; i < 8000 && done_cnt < d0 + 1; i++) begin
      start = (i == 300 || i == 2900);
      step();
    end
    start = 1'b0;
    chk("scan1_done", done_cnt, d0 + 1);
    step(3);
    chk("scan1_one_pulse", done_cnt, d0 + 1);
    chk("scan1_busy_off", busy, 0);
    chk("scan1_valid", valid, 2'b11);
    chk("scan1_mosi_count", mosi_q.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("scan1_mosi_byte%0d", i), (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, mosi_exp[i]);
    chk("sclk_period", t_r1 - t_r0, 32);
    chk_range("t6_gap", t_rd_first - t_rd_last, 350, 450);
    for (int i = 0; i < 8; i++)
      read_chk($sformatf("rd_tab%0d", i), rd_tab[i].addr, rd_tab[i].exp);

    // Continuous scanning: three scans, slave increments per conversion
    slave_data[0] = 24'h000100;
    slave_data[1] = 24'h000200;
    inc_mode = 1'b1;
    d0 = done_cnt;
    idle_cnt = 0;
    cont = 1'b1;
    step(2);
    busy_watch = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_done(d0 + s + 1, 8000, $sformatf("cont_done%0d", s));
      read_chk($sformatf("cont_ch0_scan%0d", s), 3'd0, 24'h000100 + 24'(s));
      read_chk($sformatf("cont_ch1_scan%0d", s), 3'd1, 24'h000200 + 24'(s));
      if (s == 1) begin
        step(100);
        cont = 1'b0;
        busy_watch = 1'b0;
      end
    end
    chk("cont_no_idle", idle_cnt, 0);
    step(2);
    chk("cont_busy_off", busy, 0);
    step(300);
    chk("cont_three_pulses", done_cnt, d0 + 3);
    inc_mode = 1'b0;

    // Timeout on ch0, ch1 then converts
    rst = 1'b1; step(2); rst = 1'b0; step(2);
    slave_data[1] = 24'h00BEEF;
    DRDY = 1'b1;
    step(4);
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    step(95);
    chk("to_not_early", timeout_err, 0);
    for (int i = 0; i < 15 && !timeout_err; i++) step();
    chk("to_err_set", timeout_err, 1);
    chk("to_valid0", valid[0], 0);
    chk("to_cs_high", CS, 1);
    DRDY = 1'b0;
    wait_done(d0 + 1, 8000, "to_scan_done");
    step(2);
    chk("to_valid", valid, 2'b10);
    read_chk("to_ch1_data", 3'd1, 24'h00BEEF);
    chk("to_err_sticky", timeout_err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("to_err_clr", timeout_err, 0);

    // New timeout while err_clr is held: the timeout wins for that cycle
    DRDY = 1'b1;
    err_clr = 1'b1;
    step(4);
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 150 && !timeout_err; i++) step();
    chk("to_wins_over_clr", timeout_err, 1);
    step();
    chk("to_clr_after", timeout_err, 0);
    DRDY = 1'b0;
    err_clr = 1'b0;
    wait_done(d0 + 1, 8000, "to2_scan_done");
    step(2);

    // Reset during READ after 10 bits
    rst = 1'b1; step(2); rst = 1'b0; step(2);
    d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 6000 && fb < 58; i++) step();
    chk("abort_in_read", CS, 0);
    rst = 1'b1;
    step();
    chk("abort_cs_high", CS, 1);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    step(3000);
    chk("abort_valid", valid, 0);
    chk("abort_no_done", done_cnt, d0);
    read_chk("abort_rd0", 3'd0, 24'h0);
    read_chk("abort_rd1", 3'd1, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
